apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
- APB requester (master) that converts a simple valid/ready command interface into APB3 SETUP/ACCESS transfers.
- Drives APB slaves such as the CRC8 peripheral wrapper:
  - write to offset 0x0 to feed a data byte;
  - read offset 0x4 to get the CRC value;
  - read offset 0x8 to get the state.
- Returns read data and error status on a one-cycle response strobe, and counts completed transfers.
- Sits between a CPU/test sequencer and the APB peripheral bus.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort. Used only when the optional feature is compiled in.

Ports:
- p_clk_i  in  1  clock, all logic on posedge.
- p_rst_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_W  target address.
- cmd_dat_i  in  DATA_W  write data.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_dat_o  out  DATA_W  read data; 0 for writes.
- rsp_err_o  out  1  slave error, or timeout when that feature is compiled in.
- txn_cnt_o  out  16  completed-transfer counter.
- p_sel_o  out  1  APB select.
- p_enable_o  out  1  APB enable.
- p_we_o  out  1  APB write.
- p_adr_o  out  ADDR_W  APB address.
- p_dat_o  out  DATA_W  APB write data.
- p_dat_i  in  DATA_W  APB read data.
- p_ready_i  in  1  APB ready.
- p_slverr_i  in  1  APB slave error.

Behaviour:
- Reset (p_rst_i low, asynchronous):
  - state = IDLE;
  - all outputs 0 except cmd_ready_o = 1;
  - txn_cnt_o = 0.
  - Reset mid-transfer drops p_sel_o/p_enable_o immediately and produces no response.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o:
    - latch we/adr/dat into p_we_o/p_adr_o/p_dat_o;
    - p_dat_o = 0 for reads;
    - go to SETUP with p_sel_o = 1, p_enable_o = 0.
- SETUP: exactly one cycle, then go to ACCESS with p_enable_o = 1 and p_sel_o = 1.
- ACCESS:
  - Hold all APB outputs stable until p_ready_i = 1 is sampled.
  - On that edge:
    - p_sel_o = 0, p_enable_o = 0;
    - rsp_valid_o = 1 for one cycle;
    - rsp_dat_o = p_dat_i for reads, 0 for writes;
    - rsp_err_o = p_slverr_i;
    - txn_cnt_o increments;
    - go to IDLE.
- cmd_ready_o = 0 in SETUP and ACCESS. Commands presented there are not consumed.
- Latency, with accept at edge 0:
  - SETUP during cycle 1, ACCESS from cycle 2.
  - With p_ready_i high in the first ACCESS cycle, rsp_valid_o and cmd_ready_o are high in cycle 3.
  - Minimum of 3 cycles between accepts.
  - Each extra wait cycle adds 1.
- rsp_dat_o/rsp_err_o hold their value until the next response. rsp_valid_o has no backpressure.
- txn_cnt_o:
  - counts error responses too;
  - wraps 0xFFFF -> 0x0000;
  - is not incremented by a timeout abort.
- p_ready_i/p_slverr_i are ignored outside ACCESS.
- A new command is accepted in the same cycle the previous response strobe is high.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With it defined:
  - a counter runs in ACCESS;
  - if p_ready_i is not seen within TIMEOUT_CYCLES ACCESS cycles, the transfer aborts: p_sel_o/p_enable_o = 0, rsp_valid_o = 1, rsp_err_o = 1, rsp_dat_o = 0, go to IDLE;
  - the counter clears on every entry to ACCESS.
- Without it: ACCESS waits indefinitely, and TIMEOUT_CYCLES is unused.

Test Plan:
- Reset values: hold p_rst_i low mid-ACCESS -> p_sel_o = 0, p_enable_o = 0, cmd_ready_o = 1, txn_cnt_o = 0 asynchronously, with no rsp_valid_o.
- Zero-wait write: cmd write adr 0x0, dat 0x000000A5; slave ready in the first ACCESS cycle.
  - p_sel_o high for 2 cycles, p_enable_o high for 1, p_dat_o = 0xA5.
  - rsp_valid_o high 3 cycles after accept, rsp_err_o = 0, txn_cnt_o = 1.
- Wait-state read: cmd read adr 0x4; slave holds p_ready_i low for 3 ACCESS cycles, then returns p_dat_i = 0x0000003C.
  - APB outputs stable for 4 ACCESS cycles.
  - rsp_dat_o = 0x3C, rsp_valid_o pulses once.
- Slave error plus back-to-back commands: read adr 0x8 with p_slverr_i = 1 at ready, then a second command already valid.
  - rsp_err_o = 1, txn_cnt_o increments.
  - Second command accepted on the response cycle, with SETUP the next cycle.
- Counter wrap: preload by running 65536 transfers -> txn_cnt_o returns to 0x0000.
- Timeout, with APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16: p_ready_i never asserted.
  - After 16 ACCESS cycles: p_sel_o = 0, rsp_valid_o = 1, rsp_err_o = 1, txn_cnt_o unchanged.
  - Without the macro, p_sel_o is still high after 100 cycles.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB3 requester turning valid/ready commands into SETUP/ACCESS transfers (optional APB_MASTER_TIMEOUT_EN)
module apb_master_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              p_clk_i,
    input  logic              p_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_adr_i,
    input  logic [DATA_W-1:0] cmd_dat_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_dat_o,
    output logic              rsp_err_o,
    output logic [15:0]       txn_cnt_o,
    output logic              p_sel_o,
    output logic              p_enable_o,
    output logic              p_we_o,
    output logic [ADDR_W-1:0] p_adr_o,
    output logic [DATA_W-1:0] p_dat_o,
    input  logic [DATA_W-1:0] p_dat_i,
    input  logic              p_ready_i,
    input  logic              p_slverr_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Registered APB and response outputs, with their next-cycle values
    logic              apb_sel,    apb_sel_nxt;
    logic              apb_enable, apb_enable_nxt;
    logic              apb_we,     apb_we_nxt;
    logic [ADDR_W-1:0] apb_adr,    apb_adr_nxt;
    logic [DATA_W-1:0] apb_wdat,   apb_wdat_nxt;
    logic              rsp_valid,  rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_dat,    rsp_dat_nxt;
    logic              rsp_err,    rsp_err_nxt;
    logic [15:0]       txn_cnt,    txn_cnt_nxt;

    logic accept;
    logic done;
    logic abort;

    // A zero or negative timeout would make the abort compare meaningless
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
        $error("apb_master_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    // Commands are only taken while idle; slave handshake only matters in ACCESS
    assign accept = cmd_valid_i && (state == IDLE);
    assign done   = (state == ACCESS) && p_ready_i;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts ACCESS cycles; SETUP always precedes ACCESS so clearing there restarts it per transfer
    always_ff @(posedge p_clk_i or negedge p_rst_i) begin
        if (!p_rst_i) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !p_ready_i) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Abort at the end of the last allowed ACCESS cycle; a ready in that cycle still wins
    assign abort = (state == ACCESS) && !p_ready_i && (tmo_cnt == TMO_LAST);
`else
    assign abort = 1'b0;
`endif

    // State register
    always_ff @(posedge p_clk_i or negedge p_rst_i) begin
        if (!p_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done || abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, decided by the current state
    always_comb begin
        apb_sel_nxt    = apb_sel;
        apb_enable_nxt = apb_enable;
        apb_we_nxt     = apb_we;
        apb_adr_nxt    = apb_adr;
        apb_wdat_nxt   = apb_wdat;
        rsp_valid_nxt  = 1'b0;
        rsp_dat_nxt    = rsp_dat;
        rsp_err_nxt    = rsp_err;
        txn_cnt_nxt    = txn_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    apb_sel_nxt    = 1'b1;
                    apb_enable_nxt = 1'b0;
                    apb_we_nxt     = cmd_we_i;
                    apb_adr_nxt    = cmd_adr_i;
                    apb_wdat_nxt   = cmd_we_i ? cmd_dat_i : '0;
                end
            end
            SETUP: begin
                apb_enable_nxt = 1'b1;
            end
            ACCESS: begin
                if (done) begin
                    apb_sel_nxt    = 1'b0;
                    apb_enable_nxt = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    rsp_dat_nxt    = apb_we ? '0 : p_dat_i;
                    rsp_err_nxt    = p_slverr_i;
                    txn_cnt_nxt    = txn_cnt + 16'd1;
                end else if (abort) begin
                    apb_sel_nxt    = 1'b0;
                    apb_enable_nxt = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    rsp_dat_nxt    = '0;
                    rsp_err_nxt    = 1'b1;
                end
            end
            default: begin
                apb_sel_nxt    = 1'b0;
                apb_enable_nxt = 1'b0;
            end
        endcase
    end

    // Output registers; reset drops the bus immediately and suppresses any response
    always_ff @(posedge p_clk_i or negedge p_rst_i) begin
        if (!p_rst_i) begin
            apb_sel    <= 1'b0;
            apb_enable <= 1'b0;
            apb_we     <= 1'b0;
            apb_adr    <= '0;
            apb_wdat   <= '0;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_err    <= 1'b0;
            txn_cnt    <= 16'd0;
        end else begin
            apb_sel    <= apb_sel_nxt;
            apb_enable <= apb_enable_nxt;
            apb_we     <= apb_we_nxt;
            apb_adr    <= apb_adr_nxt;
            apb_wdat   <= apb_wdat_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_dat    <= rsp_dat_nxt;
            rsp_err    <= rsp_err_nxt;
            txn_cnt    <= txn_cnt_nxt;
        end
    end

    assign cmd_ready_o = (state == IDLE);
    assign p_sel_o     = apb_sel;
    assign p_enable_o  = apb_enable;
    assign p_we_o      = apb_we;
    assign p_adr_o     = apb_adr;
    assign p_dat_o     = apb_wdat;
    assign rsp_valid_o = rsp_valid;
    assign rsp_dat_o   = rsp_dat;
    assign rsp_err_o   = rsp_err;
    assign txn_cnt_o   = txn_cnt;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - directed self-checking bench for apb_master_ctrl
module tb_apb_master_ctrl;

    logic        p_clk_i = 1'b0;
    logic        p_rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic [15:0] txn_cnt_o;
    logic        p_sel_o;
    logic        p_enable_o;
    logic        p_we_o;
    logic [31:0] p_adr_o;
    logic [31:0] p_dat_o;
    logic [31:0] p_dat_i;
    logic        p_ready_i;
    logic        p_slverr_i;

    int tests_run = 0;
    int tests_failed = 0;

    apb_master_ctrl #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .p_clk_i    (p_clk_i),
        .p_rst_i    (p_rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we_i),
        .cmd_adr_i  (cmd_adr_i),
        .cmd_dat_i  (cmd_dat_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_dat_o  (rsp_dat_o),
        .rsp_err_o  (rsp_err_o),
        .txn_cnt_o  (txn_cnt_o),
        .p_sel_o    (p_sel_o),
        .p_enable_o (p_enable_o),
        .p_we_o     (p_we_o),
        .p_adr_o    (p_adr_o),
        .p_dat_o    (p_dat_o),
        .p_dat_i    (p_dat_i),
        .p_ready_i  (p_ready_i),
        .p_slverr_i (p_slverr_i)
    );

    always #5 p_clk_i = ~p_clk_i;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge p_clk_i);
        #1;
    endtask

    // Full transfer from IDLE: accept, SETUP, ACCESS with 'waits' not-ready cycles, response
    task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input int waits, input logic [31:0] rdat, input logic err);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = wdat;
        p_ready_i   = 1'b0;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        for (int i = 0; i < waits; i++) tick();
        p_ready_i  = 1'b1;
        p_dat_i    = rdat;
        p_slverr_i = err;
        tick();
        p_ready_i  = 1'b0;
        p_slverr_i = 1'b0;
        expect_eq("xfer_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    endtask

    initial begin
        p_rst_i     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        p_dat_i     = '0;
        p_ready_i   = 1'b0;
        p_slverr_i  = 1'b0;
        tick();
        tick();
        expect_eq("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        expect_eq("rst_sel_en_rsp", {29'd0, p_sel_o, p_enable_o, rsp_valid_o}, 32'd0);
        expect_eq("rst_txn_cnt", {16'd0, txn_cnt_o}, 32'd0);
        p_rst_i = 1'b1;
        tick();

        // Zero-wait write of 0xA5 to offset 0x0
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 32'h0;
        cmd_dat_i   = 32'h0000_00A5;
        tick();
        cmd_valid_i = 1'b0;
        p_ready_i   = 1'b1;
        expect_eq("wr_setup_sel_en", {30'd0, p_sel_o, p_enable_o}, 32'd2);
        expect_eq("wr_setup_ready", {31'd0, cmd_ready_o}, 32'd0);
        expect_eq("wr_pdat", p_dat_o, 32'h0000_00A5);
        expect_eq("wr_pwe", {31'd0, p_we_o}, 32'd1);
        tick();
        expect_eq("wr_access_sel_en", {30'd0, p_sel_o, p_enable_o}, 32'd3);
        expect_eq("wr_access_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        tick();
        p_ready_i = 1'b0;
        expect_eq("wr_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        expect_eq("wr_rsp_err_dat", {rsp_dat_o[30:0], rsp_err_o}, 32'd0);
        expect_eq("wr_done_sel_en", {30'd0, p_sel_o, p_enable_o}, 32'd0);
        expect_eq("wr_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        expect_eq("wr_txn_cnt", {16'd0, txn_cnt_o}, 32'd1);
        tick();
        expect_eq("wr_rsp_one_cycle", {31'd0, rsp_valid_o}, 32'd0);

        // Read of offset 0x4 with three wait states
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h4;
        cmd_dat_i   = 32'hDEAD_BEEF;
        tick();
        cmd_valid_i = 1'b0;
        expect_eq("rd_setup_pdat_zero", p_dat_o, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_eq("rd_access_sel_en", {30'd0, p_sel_o, p_enable_o}, 32'd3);
            expect_eq("rd_access_adr", p_adr_o, 32'h4);
            expect_eq("rd_access_we_rsp", {30'd0, p_we_o, rsp_valid_o}, 32'd0);
        end
        p_ready_i = 1'b1;
        p_dat_i   = 32'h0000_003C;
        tick();
        p_ready_i = 1'b0;
        p_dat_i   = 32'h0;
        expect_eq("rd_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        expect_eq("rd_rsp_dat", rsp_dat_o, 32'h0000_003C);
        expect_eq("rd_txn_cnt", {16'd0, txn_cnt_o}, 32'd2);
        tick();
        expect_eq("rd_rsp_pulse_once", {31'd0, rsp_valid_o}, 32'd0);
        expect_eq("rd_rsp_dat_held", rsp_dat_o, 32'h0000_003C);

        // Slave error on read of 0x8, next command already waiting
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h8;
        tick();
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 32'h0;
        cmd_dat_i   = 32'h0000_0011;
        expect_eq("err_setup_not_ready", {31'd0, cmd_ready_o}, 32'd0);
        tick();
        expect_eq("err_access_adr", p_adr_o, 32'h8);
        expect_eq("err_access_not_ready", {31'd0, cmd_ready_o}, 32'd0);
        p_ready_i  = 1'b1;
        p_slverr_i = 1'b1;
        p_dat_i    = 32'h0000_0077;
        tick();
        p_ready_i  = 1'b0;
        p_slverr_i = 1'b0;
        expect_eq("err_rsp_valid_ready", {30'd0, rsp_valid_o, cmd_ready_o}, 32'd3);
        expect_eq("err_rsp_err", {31'd0, rsp_err_o}, 32'd1);
        expect_eq("err_txn_cnt", {16'd0, txn_cnt_o}, 32'd3);
        tick();
        cmd_valid_i = 1'b0;
        expect_eq("b2b_setup_sel_en", {30'd0, p_sel_o, p_enable_o}, 32'd2);
        expect_eq("b2b_setup_adr", p_adr_o, 32'h0);
        expect_eq("b2b_setup_pdat", p_dat_o, 32'h0000_0011);
        p_ready_i = 1'b1;
        tick();
        tick();
        p_ready_i = 1'b0;
        expect_eq("b2b_rsp_valid_err", {30'd0, rsp_valid_o, rsp_err_o}, 32'd2);
        expect_eq("b2b_txn_cnt", {16'd0, txn_cnt_o}, 32'd4);

        // Counter wrap: preload near the top, then two more transfers
        force dut.txn_cnt = 16'hFFFE;
        tick();
        release dut.txn_cnt;
        tick();
        expect_eq("wrap_preload", {16'd0, txn_cnt_o}, 32'h0000_FFFE);
        do_xfer(1'b0, 32'h4, 32'h0, 0, 32'h0000_0055, 1'b1);
        expect_eq("wrap_ffff", {16'd0, txn_cnt_o}, 32'h0000_FFFF);
        do_xfer(1'b1, 32'h0, 32'h0000_0001, 1, 32'h0, 1'b0);
        expect_eq("wrap_zero", {16'd0, txn_cnt_o}, 32'h0000_0000);
        tick();

        // Stalled transfer: p_ready_i never asserted
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h8;
        p_ready_i   = 1'b0;
        tick();
        cmd_valid_i = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 16; i++) tick();
        expect_eq("tmo_last_cycle_sel", {30'd0, p_sel_o, rsp_valid_o}, 32'd2);
        tick();
        expect_eq("tmo_sel_en", {30'd0, p_sel_o, p_enable_o}, 32'd0);
        expect_eq("tmo_rsp_valid_err", {30'd0, rsp_valid_o, rsp_err_o}, 32'd3);
        expect_eq("tmo_rsp_dat", rsp_dat_o, 32'h0);
        expect_eq("tmo_txn_cnt", {16'd0, txn_cnt_o}, 32'd0);
        tick();
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
`else
        for (int i = 0; i < 100; i++) tick();
        expect_eq("hang_sel_en", {30'd0, p_sel_o, p_enable_o}, 32'd3);
        expect_eq("hang_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
`endif

        // Asynchronous reset while in ACCESS
        expect_eq("pre_rst_in_access", {30'd0, p_sel_o, p_enable_o}, 32'd3);
        p_ready_i = 1'b1;
        #2;
        p_rst_i = 1'b0;
        #1;
        expect_eq("async_rst_sel_en", {30'd0, p_sel_o, p_enable_o}, 32'd0);
        expect_eq("async_rst_ready", {31'd0, cmd_ready_o}, 32'd1);
        expect_eq("async_rst_txn", {16'd0, txn_cnt_o}, 32'd0);
        tick();
        expect_eq("async_rst_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        p_rst_i   = 1'b1;
        p_ready_i = 1'b0;
        tick();
        expect_eq("post_rst_idle", {29'd0, p_sel_o, rsp_valid_o, cmd_ready_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
